// File: rtl/vl4_mul_seq_decoder.sv
// Receive-side checker for the 4-phase constant-multiply sequencer (x1, x3, x7, x8 words).
// Latency: d_valid pulses 1 cycle after the x8 word is sampled (4 cycles after the x1 word).
// Backpressure: none; in_data is sampled every cycle, and a new grant aborts the frame in flight.
//
// Ports: clk, rst (async active-low); in_grant/in_data (product stream, grant marks the x1 word);
//        d_out/d_valid/d_err/err_phase (per-frame result), frame_abort, busy, err_cnt.
// Optional: define VL4_MUL_SEQ_DEC_ERRCNT_EN to build the saturating errored-frame counter;
//           without it err_cnt is tied to 0 and the port list is unchanged.
module vl4_mul_seq_decoder #(
    parameter int DW  = 8,
    parameter int OW  = 11,
    parameter int ECW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_grant,
    input  logic [OW-1:0] in_data,
    output logic [DW-1:0] d_out,
    output logic          d_valid,
    output logic          d_err,
    output logic [1:0]    err_phase,
    output logic          frame_abort,
    output logic          busy,
    output logic [ECW-1:0] err_cnt
);

    // Encoding chosen so a state's value equals the phase index it checks.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_P3   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   d_cap, d_cap_nxt;
    logic            err_seen, err_seen_nxt;   // any mismatch so far in this frame
    logic [1:0]      err_ph, err_ph_nxt;       // first failing phase so far
    logic [DW-1:0]   d_out_nxt;
    logic            d_valid_nxt, d_err_nxt, frame_abort_nxt;
    logic [1:0]      err_phase_nxt;

    logic [OW-1:0]   dx;
    logic [OW-1:0]   exp_word;
    logic            mm;
    logic            mm0;
    logic [1:0]      cur_ph;
    logic            fin_err;
    logic [1:0]      fin_ph;

    assign dx     = {{(OW-DW){1'b0}}, d_cap};
    assign cur_ph = state;
    assign mm0    = |in_data[OW-1:DW];

    // Expected product for the phase being checked; shifts and adds only.
    always_comb begin
        exp_word = '0;
        case (state)
            S_P1:    exp_word = (dx << 1) + dx;
            S_P2:    exp_word = (dx << 3) - dx;
            S_P3:    exp_word = dx << 3;
            default: exp_word = '0;
        endcase
    end

    assign mm      = (in_data != exp_word);
    assign fin_err = err_seen | mm;
    // Earlier failure wins; otherwise this phase if it failed, else 0.
    assign fin_ph  = err_seen ? err_ph : (mm ? cur_ph : 2'd0);

    always_comb begin
        state_nxt       = state;
        d_cap_nxt       = d_cap;
        err_seen_nxt    = err_seen;
        err_ph_nxt      = err_ph;
        d_out_nxt       = d_out;
        d_valid_nxt     = 1'b0;
        d_err_nxt       = d_err;
        err_phase_nxt   = err_phase;
        frame_abort_nxt = 1'b0;

        if (in_grant) begin
            // A grant always starts a new frame, even in P3; any frame in flight is dropped.
            frame_abort_nxt = (state != S_IDLE);
            d_cap_nxt       = in_data[DW-1:0];
            err_seen_nxt    = mm0;
            err_ph_nxt      = 2'd0;
            state_nxt       = S_P1;
        end else begin
            case (state)
                S_P1: begin
                    err_seen_nxt = fin_err;
                    err_ph_nxt   = fin_ph;
                    state_nxt    = S_P2;
                end
                S_P2: begin
                    err_seen_nxt = fin_err;
                    err_ph_nxt   = fin_ph;
                    state_nxt    = S_P3;
                end
                S_P3: begin
                    d_out_nxt     = d_cap;
                    d_valid_nxt   = 1'b1;
                    d_err_nxt     = fin_err;
                    err_phase_nxt = fin_err ? fin_ph : 2'd0;
                    err_seen_nxt  = 1'b0;
                    err_ph_nxt    = 2'd0;
                    state_nxt     = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            d_cap       <= '0;
            err_seen    <= 1'b0;
            err_ph      <= 2'd0;
            d_out       <= '0;
            d_valid     <= 1'b0;
            d_err       <= 1'b0;
            err_phase   <= 2'd0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            d_cap       <= d_cap_nxt;
            err_seen    <= err_seen_nxt;
            err_ph      <= err_ph_nxt;
            d_out       <= d_out_nxt;
            d_valid     <= d_valid_nxt;
            d_err       <= d_err_nxt;
            err_phase   <= err_phase_nxt;
            frame_abort <= frame_abort_nxt;
        end
    end

    assign busy = (state != S_IDLE);

`ifdef VL4_MUL_SEQ_DEC_ERRCNT_EN
    logic [ECW-1:0] err_cnt_q;

    // Counts with the completed-frame result; aborted frames never reach d_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (d_valid_nxt && d_err_nxt && (err_cnt_q != {ECW{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_vl4_mul_seq_decoder.sv
// Self-checking bench for vl4_mul_seq_decoder: directed frames plus randomized frames
// compared cycle by cycle against a frame-list reference model.
module tb_vl4_mul_seq_decoder;

    localparam int DW  = 8;
    localparam int OW  = 11;
    localparam int ECW = 16;

    logic           clk;
    logic           rst;
    logic           in_grant;
    logic [OW-1:0]  in_data;
    logic [DW-1:0]  d_out;
    logic           d_valid;
    logic           d_err;
    logic [1:0]     err_phase;
    logic           frame_abort;
    logic           busy;
    logic [ECW-1:0] err_cnt;

    vl4_mul_seq_decoder #(.DW(DW), .OW(OW), .ECW(ECW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_grant    (in_grant),
        .in_data     (in_data),
        .d_out       (d_out),
        .d_valid     (d_valid),
        .d_err       (d_err),
        .err_phase   (err_phase),
        .frame_abort (frame_abort),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int  mults[4] = '{1, 3, 7, 8};
    int  m_frame[$];
    bit  m_active;
    int  m_dout, m_derr, m_ph, m_valid, m_abort, m_cnt;

    task automatic model_reset();
        m_frame.delete();
        m_active = 0;
        m_dout = 0; m_derr = 0; m_ph = 0; m_valid = 0; m_abort = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit g, input int w);
        int d, first;
        m_valid = 0;
        m_abort = 0;
        if (g) begin
            if (m_active) m_abort = 1;
            m_frame.delete();
            m_frame.push_back(w);
            m_active = 1;
        end else if (m_active) begin
            m_frame.push_back(w);
            if (m_frame.size() == 4) begin
                d = m_frame[0] % 256;
                first = -1;
                for (int i = 0; i < 4; i++)
                    if (m_frame[i] != d * mults[i] && first < 0) first = i;
                m_dout  = d;
                m_valid = 1;
                m_derr  = (first >= 0) ? 1 : 0;
                m_ph    = (first >= 0) ? first : 0;
`ifdef VL4_MUL_SEQ_DEC_ERRCNT_EN
                if (m_derr == 1 && m_cnt < 65535) m_cnt++;
`endif
                m_active = 0;
            end
        end
    endtask

    task automatic compare_all(input string where);
        chk({where, ".d_out"},       32'(d_out),       32'(m_dout));
        chk({where, ".d_valid"},     32'(d_valid),     32'(m_valid));
        chk({where, ".d_err"},       32'(d_err),       32'(m_derr));
        chk({where, ".err_phase"},   32'(err_phase),   32'(m_ph));
        chk({where, ".frame_abort"}, 32'(frame_abort), 32'(m_abort));
        chk({where, ".busy"},        32'(busy),        32'(m_active));
        chk({where, ".err_cnt"},     32'(err_cnt),     32'(m_cnt));
    endtask

    // Drive one word, clock it, then check all outputs 1 ns after the edge.
    task automatic step(input bit g, input int w, input string where);
        in_grant = g;
        in_data  = OW'(w);
        @(posedge clk);
        model_edge(g, w);
        #1;
        compare_all(where);
    endtask

    task automatic send_frame(input int d, input int corrupt, input int len);
        int w;
        for (int i = 0; i < len; i++) begin
            w = d * mults[i];
            if (corrupt[i]) begin
                if (i == 0) w = d | (int'($urandom_range(1, 7)) << 8);
                else        w = w ^ (1 << $urandom_range(0, 10));
            end
            step(i == 0, w, "rnd");
        end
    endtask

    initial begin
        int vc;
        rst      = 1'b0;
        in_grant = 1'b0;
        in_data  = '0;
        model_reset();
        #12;
        compare_all("reset");
        #8;
        rst = 1'b1;   // released at 20 ns

        // Basic frame d=100.
        step(1, 100, "t1"); step(0, 300, "t1"); step(0, 700, "t1"); step(0, 800, "t1");
        chk("t1.d_out_const", 32'(d_out), 32'd100);
        chk("t1.d_valid_const", 32'(d_valid), 32'd1);
        step(0, 0, "t1_idle");
        chk("t1.busy_after", 32'(busy), 32'd0);

        // Back-to-back extremes; d_valid spacing must be exactly 4.
        vc = 0;
        step(1, 255, "t2"); step(0, 765, "t2"); step(0, 1785, "t2"); step(0, 2040, "t2");
        step(1, 0, "t2");
        chk("t2.d_out_255", 32'(d_out), 32'd255);
        step(0, 0, "t2"); step(0, 0, "t2"); step(0, 0, "t2");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, "t2_tail");
            if (d_valid) vc = i;
        end
        chk("t2.valid_gap", 32'(vc), 32'd0);
        chk("t2.d_out_0", 32'(d_out), 32'd0);

        // Errors at phases 2 and 3: first failing phase is 2.
        step(1, 100, "t3"); step(0, 300, "t3"); step(0, 701, "t3"); step(0, 801, "t3");
        chk("t3.err_phase", 32'(err_phase), 32'd2);
        chk("t3.d_err", 32'(d_err), 32'd1);

        // Phase-0 upper bits set.
        step(1, 'h164, "t4"); step(0, 300, "t4"); step(0, 700, "t4"); step(0, 800, "t4");
        chk("t4.err_phase", 32'(err_phase), 32'd0);
        chk("t4.d_err", 32'(d_err), 32'd1);

        // Abort by early grant.
        step(1, 100, "t5"); step(0, 300, "t5"); step(1, 50, "t5");
        chk("t5.abort", 32'(frame_abort), 32'd1);
        step(0, 150, "t5"); step(0, 350, "t5"); step(0, 400, "t5");
        chk("t5.d_out", 32'(d_out), 32'd50);

        // Grant arriving in P3 takes priority over completion.
        step(1, 10, "t6"); step(0, 30, "t6"); step(0, 70, "t6"); step(1, 9, "t6");
        chk("t6.abort_p3", 32'(frame_abort), 32'd1);
        step(0, 27, "t6"); step(0, 63, "t6"); step(0, 72, "t6");

        // Asynchronous reset during P2.
        step(1, 100, "t7"); step(0, 300, "t7");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all("t7_rst");
        in_grant = 1'b1; in_data = OW'(77);
        @(posedge clk);
        #1;
        compare_all("t7_rst_hold");
        @(negedge clk);
        rst = 1'b1;
        step(1, 20, "t7"); step(0, 60, "t7"); step(0, 140, "t7"); step(0, 160, "t7");
        chk("t7.d_out", 32'(d_out), 32'd20);
        step(0, 0, "t7");

        // Randomized frames: corruption, truncation (early grant), idle gaps.
        for (int f = 0; f < 300; f++) begin
            int d, corrupt, len, gap;
            d       = $urandom_range(0, 255);
            if (f % 7 == 0) d = (f % 14 == 0) ? 0 : 255;
            corrupt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
            len     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 4;
            gap     = $urandom_range(0, 2);
            send_frame(d, corrupt, len);
            if (len == 4)
                for (int k = 0; k < gap; k++) step(0, $urandom_range(0, 2047), "rnd_gap");
        end
        step(0, 0, "final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vl4_mul_seq_decoder.md
Name: vl4_mul_seq_decoder

Overview:
- Receive-side checker/decoder for the 4-phase constant-multiply sequencer (d×1, d×3, d×7, d×8 on an 11-bit bus, input_grant marking the ×1 word).
- Recovers the 8-bit operand, verifies the remaining three product words, and reports one result per frame.
- Sits directly downstream of the multiply sequencer. Used in benches and in loopback self-check of the datapath.

Parameters:
- DW, 8, operand width.
- OW, 11, product bus width; must be ≥ DW+3.
- ECW, 16, error-counter width (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_grant  input  1  high on the cycle carrying the ×1 word (phase 0) of a frame.
- in_data  input  OW  product word, sampled every rising edge.
- d_out  output  DW  recovered operand; holds its value until the next completed frame.
- d_valid  output  1  one-cycle pulse when d_out and d_err update.
- d_err  output  1  frame had at least one mismatching word; valid with d_valid.
- err_phase  output  2  first failing phase (0..3); valid with d_valid when d_err=1, else 0.
- frame_abort  output  1  one-cycle pulse; in_grant arrived before the current frame completed.
- busy  output  1  high while in states P1..P3.
- err_cnt  output  ECW  saturating count of errored frames; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0.
  - Captured operand and error flags cleared.
  - A frame in flight is discarded: no d_valid, no frame_abort.
- FSM states: IDLE, P1, P2, P3. All outputs are registered.
- IDLE:
  - in_grant=0: in_data ignored.
  - in_grant=1: capture d_cap=in_data[DW-1:0]. Phase-0 check: in_data[OW-1:DW] must be 0, else record mismatch at phase 0. Go to P1.
- Expected words (full OW-bit compare, built from shifts/adds, no multiplier):
  - P1: in_data == d_cap×3 = (d_cap<<1)+d_cap. Go to P2.
  - P2: in_data == d_cap×7 = (d_cap<<3)-d_cap. Go to P3.
  - P3: in_data == d_cap×8 = d_cap<<3.
- End of frame, in P3 with in_grant=0:
  - Next cycle: d_out=d_cap, d_valid=1, d_err=(any mismatch), err_phase=lowest failing phase. Go to IDLE.
  - Latency: d_valid asserts exactly one cycle after the ×8 word is sampled, i.e. 4 cycles after the ×1 word.
- Mismatch tracking: only the first failing phase is recorded. Later mismatches in the same frame set d_err but do not change err_phase.
- in_grant=1 while in P1, P2 or P3:
  - The current frame is abandoned: frame_abort=1 next cycle, no d_valid for it.
  - That word is treated as phase 0 of a new frame; capture and go to P1.
  - Applies in P3 too: the grant takes priority over completing the frame.
- Back-to-back frames (in_grant every 4th cycle): no bubble.
  - The P3→IDLE transition and the IDLE grant check collapse, so a grant in the cycle after P3 is accepted.
  - d_valid occurs every 4 cycles.
- Extreme values: d=0 gives all-zero words, no error. d=255 gives 255/765/1785/2040, which fits OW=11 with no overflow.
- d_valid and frame_abort are never high in the same cycle.

Optional Feature:
- Macro: VL4_MUL_SEQ_DEC_ERRCNT_EN.
- Defined: err_cnt increments by 1 in the cycle d_valid=1 with d_err=1.
  - Saturates at 2^ECW-1.
  - Aborted frames are not counted.
  - Cleared only by reset.
- Undefined: no counter logic is instantiated; err_cnt is tied to 0. The port list is identical in both builds.

Test Plan:
- Release reset at 20 ns. Phase words 100 (grant=1), 300, 700, 800 → one cycle after 800: d_out=100, d_valid=1 for one cycle, d_err=0, err_phase=0, busy low afterwards.
- Phase words 255, 765, 1785, 2040, then 0, 0, 0, 0 back-to-back with grant every 4 cycles → d_out=255 then 0, d_valid pulses exactly 4 cycles apart, no errors.
- Phase words 100, 300, 701, 801 → d_valid=1, d_err=1, err_phase=2, d_out=100. With the macro defined, err_cnt goes 0→1.
- Phase-0 word 0x164 (bits[10:8]≠0), then 100, 300, 700, 800 → d_err=1, err_phase=0.
- Words 100, 300, then in_grant=1 with 50, followed by 150, 350, 400 → frame_abort pulse one cycle after the grant, no d_valid for 100; d_valid with d_out=50, d_err=0.
- Drive rst=0 during P2 of a d=100 frame, release, then send 20, 60, 140, 160 → all outputs 0 during reset, no d_valid for 100; d_out=20, d_valid=1, err_cnt unchanged by the interrupted frame.
